lcd_hex_driver: RTL and testbench
=================================

# lcd_hex_driver

Character-LCD controller that sits directly downstream of the processor's display-select stage. It takes the selected 32-bit `Result` word and shows it on an HD44780-compatible 16x2 module as 8 uppercase hex digits on line 1. The FSM runs the power-on init sequence, then refreshes continuously. Each refresh frame samples the input word once, so a frame never shows a mix of two values.

## Interface
- `PWR_WAIT`, default 750000: cycles of idle after reset before the first command (15 ms at 50 MHz).
- `E_PULSE`, default 12: cycles `LCD_E` is held high per transfer; must be ≥1.
- `CMD_WAIT`, default 2000: post-pulse wait for normal commands and data writes (40 µs).
- `CLR_WAIT`, default 82000: post-pulse wait after Clear Display (1.64 ms).
- `CLK` input 1: single clock; all state changes on rising edge.
- `RST` input 1: synchronous, active-high reset.
- `Result` input 32: value to display; sampled at frame start.
- `LCD_RS` output 1: 0 = command, 1 = data.
- `LCD_RW` output 1: tied 0 (write only).
- `LCD_E` output 1: enable strobe.
- `LCD_DATA` output 8: 8-bit bus.
- `Ready` output 1: high once init completes; stays high until reset.
- `FrameDone` output 1: one-cycle pulse after the last character of each frame.

## Operation
- States: `S_PWR` → `S_INIT` → `S_ADDR` → `S_CHAR` → back to `S_ADDR`, looping forever.
- `S_PWR`
  - Counts `PWR_WAIT` cycles with all outputs at reset values.
  - Then enters `S_INIT` with index 0.
- `S_INIT`
  - Issues commands in this order, `RS`=0: 0x38 (8-bit, 2 lines), 0x0C (display on, cursor off), 0x06 (entry increment), 0x01 (clear).
  - Clear uses `CLR_WAIT`; the others use `CMD_WAIT`.
  - After the clear, `Ready`←1 and the FSM enters `S_ADDR`.
- `S_ADDR`
  - On entry, latches `Result` into a 32-bit frame register.
  - Issues command 0x80 (DDRAM address 0), `RS`=0, then enters `S_CHAR` with index 0.
- `S_CHAR`
  - Writes characters with `RS`=1, most-significant nibble first.
  - Nibble n maps to 0x30+n for n≤9 and 0x37+n for n≥10 (so 0xA→0x41).
  - After the last character: `FrameDone` pulses, then the FSM re-enters `S_ADDR`.
- Each byte transfer has three phases:
  - SETUP: 1 cycle. `RS` and `DATA` valid, `E`=0.
  - PULSE: `E_PULSE` cycles. `E`=1; `RS` and `DATA` unchanged.
  - WAIT: `CMD_WAIT` or `CLR_WAIT` cycles. `E`=0; `RS` and `DATA` held.
- Per-transfer duration: 1+`E_PULSE`+wait cycles.
- A single down-counter, wide enough for `PWR_WAIT`, serves all delays.
- `Result` changes mid-frame are ignored until the next `S_ADDR` entry.

## Timing
- Reset values: `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DATA`=0x00, `Ready`=0, `FrameDone`=0, frame register=0. State is `S_PWR` with the counter loaded to `PWR_WAIT`.
- First rising edge of `LCD_E`: exactly `PWR_WAIT`+1 cycles after the cycle in which `RST` is deasserted.
- `Ready` rises in the first cycle of the first `S_ADDR` SETUP phase.
- `FrameDone` is high in the cycle after the last WAIT cycle of the final character; that cycle is also the next frame's first SETUP cycle.
- `RST` asserted in any state, including mid-pulse, returns to reset values on the next edge, and the full init sequence reruns. `LCD_E` never stays high across reset.
- `LCD_DATA` and `LCD_RS` never change while `LCD_E`=1.

## Configuration
- `LCD_PREFIX_EN`
  - Defined: each frame writes "0x" (0x30, 0x78) before the 8 digits, giving 10 characters.
  - Undefined: 8 characters only, with no prefix logic.
- The character index width and the last-index compare follow the macro.

## Test plan
Bench parameters: `PWR_WAIT`=10, `E_PULSE`=2, `CMD_WAIT`=4, `CLR_WAIT`=8.
- Reset release → `LCD_E` stays 0 for 11 cycles, then bus sequence 0x38, 0x0C, 0x06, 0x01 with `RS`=0. Each `E` pulse is 2 cycles. Gaps after the pulse are 4, 4, 4, and 8 cycles.
- `Result`=0x1234ABCD → after 0x80, data bytes 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44 with `RS`=1, then a one-cycle `FrameDone` pulse.
- `Result` changed from 0x00000000 to 0xFFFFFFFF during the 3rd character → the current frame completes with all 0x30; the next frame is all 0x46.
- `RST` pulsed while `LCD_E`=1 during character 5 → next cycle `LCD_E`=0, `Ready`=0, `DATA`=0x00; the init sequence then repeats exactly as in the first scenario.
- Protocol monitor over 3 frames → `RS` and `DATA` are stable whenever `E`=1, every `E` pulse is exactly 2 cycles, and `RW` is always 0.
- With `LCD_PREFIX_EN` defined and `Result`=0x0000000F → frame bytes 0x30,0x78, then seven 0x30, then 0x46.

Source files
------------

// File: rtl/lcd_hex_driver.sv
// HD44780 16x2 driver: power-on init, then endless refresh of a 32-bit word as 8 hex digits on line 1.
// Optional build macro LCD_PREFIX_EN prepends "0x" to every frame (10 characters instead of 8).
module lcd_hex_driver #(
   parameter int PWR_WAIT = 750000,
   parameter int E_PULSE  = 12,
   parameter int CMD_WAIT = 2000,
   parameter int CLR_WAIT = 82000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Result,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_E,
   output logic [7:0]  LCD_DATA,
   output logic        Ready,
   output logic        FrameDone
);

   localparam int M1   = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
   localparam int M2   = (CMD_WAIT > E_PULSE) ? CMD_WAIT : E_PULSE;
   localparam int MAXV = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(MAXV + 1);

   localparam logic [CW-1:0] PWR_LD   = CW'(PWR_WAIT);
   localparam logic [CW-1:0] PULSE_LD = CW'(E_PULSE - 1);
   localparam logic [CW-1:0] CMD_LD   = CW'(CMD_WAIT - 1);
   localparam logic [CW-1:0] CLR_LD   = CW'(CLR_WAIT - 1);

`ifdef LCD_PREFIX_EN
   localparam int IW = 4;
   localparam logic [IW-1:0] LAST = 4'd9;
`else
   localparam int IW = 3;
   localparam logic [IW-1:0] LAST = 3'd7;
`endif

   typedef enum logic [1:0] {S_PWR, S_INIT, S_ADDR, S_CHAR} state_t;
   typedef enum logic [1:0] {P_SETUP, P_PULSE, P_WAIT} phase_t;

   state_t        state;
   phase_t        phase;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [31:0]   frame;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // Digits are taken from the frame register, most-significant nibble first.
   function automatic logic [7:0] char_at(input logic [31:0] w, input logic [IW-1:0] i);
      logic [31:0] s;
`ifdef LCD_PREFIX_EN
      if (i == 4'd0) return 8'h30;
      if (i == 4'd1) return 8'h78;
      s = w << {i - 4'd2, 2'b00};
`else
      s = w << {i, 2'b00};
`endif
      return hex_char(s[31:28]);
   endfunction

   assign LCD_RW = 1'b0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= S_PWR;
         phase     <= P_SETUP;
         cnt       <= PWR_LD;
         idx       <= '0;
         frame     <= '0;
         LCD_RS    <= 1'b0;
         LCD_E     <= 1'b0;
         LCD_DATA  <= 8'h00;
         Ready     <= 1'b0;
         FrameDone <= 1'b0;
      end else begin
         FrameDone <= 1'b0;
         if (state == S_PWR) begin
            // Leaving one count early makes the SETUP cycle the last idle cycle.
            if (cnt <= CW'(1)) begin
               state    <= S_INIT;
               phase    <= P_SETUP;
               idx      <= '0;
               LCD_RS   <= 1'b0;
               LCD_DATA <= init_cmd(2'd0);
            end else begin
               cnt <= cnt - CW'(1);
            end
         end else begin
            case (phase)
               P_SETUP: begin
                  LCD_E <= 1'b1;
                  cnt   <= PULSE_LD;
                  phase <= P_PULSE;
               end
               P_PULSE: begin
                  if (cnt == '0) begin
                     LCD_E <= 1'b0;
                     phase <= P_WAIT;
                     cnt   <= (state == S_INIT && idx == IW'(3)) ? CLR_LD : CMD_LD;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               P_WAIT: begin
                  if (cnt == '0) begin
                     phase <= P_SETUP;
                     case (state)
                        S_INIT: begin
                           if (idx == IW'(3)) begin
                              Ready    <= 1'b1;
                              state    <= S_ADDR;
                              LCD_RS   <= 1'b0;
                              LCD_DATA <= 8'h80;
                              frame    <= Result;
                           end else begin
                              idx      <= idx + IW'(1);
                              LCD_DATA <= init_cmd(idx[1:0] + 2'd1);
                           end
                        end
                        S_ADDR: begin
                           state    <= S_CHAR;
                           idx      <= '0;
                           LCD_RS   <= 1'b1;
                           LCD_DATA <= char_at(frame, '0);
                        end
                        default: begin
                           if (idx == LAST) begin
                              FrameDone <= 1'b1;
                              state     <= S_ADDR;
                              LCD_RS    <= 1'b0;
                              LCD_DATA  <= 8'h80;
                              frame     <= Result;
                           end else begin
                              idx      <= idx + IW'(1);
                              LCD_DATA <= char_at(frame, idx + IW'(1));
                           end
                        end
                     endcase
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               default: phase <= P_SETUP;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Randomized bench for lcd_hex_driver: a bus monitor records every E pulse and a
// transaction-level model of the expected LCD byte stream is compared against it.
module tb_lcd_hex_driver;

   localparam int PWR_WAIT = 10;
   localparam int E_PULSE  = 2;
   localparam int CMD_WAIT = 4;
   localparam int CLR_WAIT = 8;
`ifdef LCD_PREFIX_EN
   localparam int NCH = 10;
`else
   localparam int NCH = 8;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] result;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_e;
   logic [7:0]  lcd_data;
   logic        ready;
   logic        frame_done;

   lcd_hex_driver #(
      .PWR_WAIT(PWR_WAIT), .E_PULSE(E_PULSE), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)
   ) dut (
      .CLK(clk), .RST(rst), .Result(result),
      .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e), .LCD_DATA(lcd_data),
      .Ready(ready), .FrameDone(frame_done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_seen;
   always @(posedge clk) rst_seen <= rst;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // bus monitor: one record per completed E pulse
   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         low;
      int         plen;
      int         fd;
      logic       rdy;
   } obs_t;
   obs_t obs_q[$];

   obs_t cur;
   bit   in_pulse = 0;
   int   low_run  = 0;
   int   fd_run   = 0;
   logic prev_ready = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(negedge clk) begin
      check_eq("rw_low", {31'd0, lcd_rw}, 32'd0);
      if (rst_seen) begin
         low_run  = 1;
         in_pulse = 0;
         fd_run   = 0;
      end else begin
         if (frame_done) fd_run++;
         if (ready && !prev_ready) begin
            check_eq("ready_rise.data", {24'd0, lcd_data}, 32'h80);
            check_eq("ready_rise.prev_data", {24'd0, prev_data}, 32'h01);
         end
         if (lcd_e) begin
            if (!in_pulse) begin
               in_pulse = 1;
               cur.rs   = lcd_rs;
               cur.data = lcd_data;
               cur.low  = low_run;
               cur.fd   = fd_run;
               cur.rdy  = ready;
               cur.plen = 0;
            end else begin
               check_eq("stable.data", {24'd0, lcd_data}, {24'd0, cur.data});
               check_eq("stable.rs", {31'd0, lcd_rs}, {31'd0, cur.rs});
            end
            cur.plen++;
         end else if (in_pulse) begin
            obs_q.push_back(cur);
            in_pulse = 0;
            low_run  = 1;
            fd_run   = 0;
         end else begin
            low_run++;
         end
      end
      prev_ready = ready;
      prev_data  = lcd_data;
   end

   // reference model: {ready, framedone_before, low_cycles_before, rs, data}
   logic [18:0] exp_q[$];
   int next_low;

   task automatic model_xfer(input logic rs, input logic [7:0] d, input int w,
                             input logic fd, input logic rdy);
      logic [7:0] lw;
      lw = 8'(next_low);
      exp_q.push_back({rdy, fd, lw, rs, d});
      next_low = w + 1;
   endtask

   task automatic model_init();
      next_low = PWR_WAIT + 1;
      model_xfer(1'b0, 8'h38, CMD_WAIT, 1'b0, 1'b0);
      model_xfer(1'b0, 8'h0C, CMD_WAIT, 1'b0, 1'b0);
      model_xfer(1'b0, 8'h06, CMD_WAIT, 1'b0, 1'b0);
      model_xfer(1'b0, 8'h01, CLR_WAIT, 1'b0, 1'b0);
   endtask

   task automatic model_frame(input logic [31:0] v, input logic fd);
      int dig;
      model_xfer(1'b0, 8'h80, CMD_WAIT, fd, 1'b1);
`ifdef LCD_PREFIX_EN
      model_xfer(1'b1, "0", CMD_WAIT, 1'b0, 1'b1);
      model_xfer(1'b1, "x", CMD_WAIT, 1'b0, 1'b1);
`endif
      for (int i = 0; i < 8; i++) begin
         dig = (v / (32'd1 << (28 - 4 * i))) % 16;
         if (dig < 10) model_xfer(1'b1, 8'("0" + dig), CMD_WAIT, 1'b0, 1'b1);
         else          model_xfer(1'b1, 8'("A" + dig - 10), CMD_WAIT, 1'b0, 1'b1);
      end
   endtask

   // scoreboard
   int xfer_no = 0;

   task automatic compare_next();
      obs_t        o;
      logic [18:0] e;
      int          n;
      n = 0;
      while (obs_q.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
         check_eq($sformatf("x%0d.timeout", xfer_no), obs_q.size(), 1);
      end else begin
         o = obs_q.pop_front();
         check_eq($sformatf("x%0d.data", xfer_no), {24'd0, o.data}, {24'd0, e[7:0]});
         check_eq($sformatf("x%0d.rs", xfer_no), {31'd0, o.rs}, {31'd0, e[8]});
         check_eq($sformatf("x%0d.gap", xfer_no), o.low, {24'd0, e[16:9]});
         check_eq($sformatf("x%0d.pulse", xfer_no), o.plen, E_PULSE);
         check_eq($sformatf("x%0d.framedone", xfer_no), o.fd, {31'd0, e[17]});
         check_eq($sformatf("x%0d.ready", xfer_no), {31'd0, o.rdy}, {31'd0, e[18]});
      end
      xfer_no++;
   endtask

   task automatic compare_n(input int n);
      for (int i = 0; i < n; i++) compare_next();
   endtask

   task automatic wait_e_high();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!lcd_e && n < 200);
      check_eq("wait_e_high", {31'd0, lcd_e}, 32'd1);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, ".e"}, {31'd0, lcd_e}, 32'd0);
      check_eq({tag, ".rs"}, {31'd0, lcd_rs}, 32'd0);
      check_eq({tag, ".data"}, {24'd0, lcd_data}, 32'd0);
      check_eq({tag, ".ready"}, {31'd0, ready}, 32'd0);
      check_eq({tag, ".framedone"}, {31'd0, frame_done}, 32'd0);
   endtask

   // driver / scenarios
   initial begin
      rst    = 1'b1;
      result = 32'h1234ABCD;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      model_init();
      model_frame(32'h1234ABCD, 1'b0);
      compare_n(6);
      result = 32'h0000_0000;
      compare_n(NCH - 1);

      model_frame(32'h0000_0000, 1'b1);
      compare_n(3);
      wait_e_high();
      result = 32'hFFFF_FFFF;
      compare_n(NCH - 2);

      model_frame(32'hFFFF_FFFF, 1'b1);
      compare_n(2);
      result = 32'h0000_000F;
      compare_n(NCH - 1);

      model_frame(32'h0000_000F, 1'b1);
      compare_n(1 + NCH);

      for (int f = 0; f < 4; f++) begin
         model_frame(result, 1'b1);
         compare_n(1);
         for (int i = 0; i < NCH; i++) begin
            compare_next();
            if (i < NCH - 2 && (i == 0 || $urandom_range(0, 2) == 0)) result = $urandom;
         end
      end

      // reset pulsed in the middle of the fifth character's E pulse
      model_frame(result, 1'b1);
      compare_n(5);
      wait_e_high();
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("midpulse_reset");
      rst = 1'b0;
      exp_q.delete();
      model_init();
      model_frame(result, 1'b0);
      compare_n(5 + NCH);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
